// File: rtl/morse_key_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | morse_key_classifier                                                     |
// | Syncs/debounces a keyer line and classifies marks and spaces into        |
// | Dot/Dash/Lg/Wg events with a one-cycle Valid qualifier.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module morse_key_classifier #(
   parameter int CNT_W      = 8,
   parameter int DEB_CYCLES = 4,
   parameter int MIN_MARK   = 1,
   parameter int DASH_MIN   = 8,
   parameter int LG_MIN     = 8,
   parameter int WG_MIN     = 20
) (
   input  logic Clk,
   input  logic Clr,
   input  logic Key,
   input  logic Tick,
   output logic Dot,
   output logic Dash,
   output logic Lg,
   output logic Wg,
   output logic Valid
);

   localparam int c_deb_w = $clog2(DEB_CYCLES + 1);
   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
   localparam logic [CNT_W-1:0]   c_min_mark = CNT_W'(MIN_MARK);
   localparam logic [CNT_W-1:0]   c_dash_min = CNT_W'(DASH_MIN);
   localparam logic [CNT_W-1:0]   c_lg_min   = CNT_W'(LG_MIN);
   localparam logic [CNT_W-1:0]   c_wg_min   = CNT_W'(WG_MIN);

   localparam logic [3:0] c_ev_dot  = 4'b1000;
   localparam logic [3:0] c_ev_dash = 4'b0100;
   localparam logic [3:0] c_ev_lg   = 4'b0010;
   localparam logic [3:0] c_ev_wg   = 4'b0001;

   typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2, GAP = 2'd3} state_t;

   state_t               r_state, w_state_nx;
   state_t               r_ret, w_ret_nx;
   logic [1:0]           r_sync;
   logic [c_deb_w-1:0]   r_deb_cnt;
   logic                 r_kd;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_inc;
   logic                 w_cnt_clr;
   logic                 w_fire;
   logic [3:0]           w_ev;
   logic [3:0]           r_ev;
   logic                 r_valid;

   // kd only moves after the synced level has disagreed for DEB_CYCLES cycles in a row
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_sync    <= 2'b00;
         r_deb_cnt <= '0;
         r_kd      <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], Key};
         if (r_sync[1] == r_kd) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == c_deb_last) begin
            r_deb_cnt <= '0;
            r_kd      <= r_sync[1];
         end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
         end
      end
   end

   assign w_cnt_inc = (Tick && (r_cnt != c_cnt_max)) ? r_cnt + CNT_W'(1) : r_cnt;

   always_comb begin
      w_state_nx = r_state;
      w_ret_nx   = r_ret;
      w_cnt_clr  = 1'b0;
      w_fire     = 1'b0;
      w_ev       = c_ev_dot;
      case (r_state)
         IDLE: begin
            if (r_kd) begin
               w_state_nx = MARK;
               w_ret_nx   = IDLE;
               w_cnt_clr  = 1'b1;
            end
         end
         MARK: begin
            if (!r_kd) begin
               w_cnt_clr = 1'b1;
               if (r_cnt < c_min_mark) begin
                  w_state_nx = r_ret;
               end else begin
                  w_fire     = 1'b1;
                  w_ev       = (r_cnt >= c_dash_min) ? c_ev_dash : c_ev_dot;
                  w_state_nx = SPACE;
               end
            end
         end
         SPACE: begin
            // a gap threshold coinciding with a new mark still reports the gap first
            if (w_cnt_inc >= c_lg_min) begin
               w_fire     = 1'b1;
               w_ev       = c_ev_lg;
               w_cnt_clr  = 1'b1;
               w_state_nx = r_kd ? MARK : GAP;
               w_ret_nx   = GAP;
            end else if (r_kd) begin
               w_state_nx = MARK;
               w_ret_nx   = SPACE;
               w_cnt_clr  = 1'b1;
            end
         end
         GAP: begin
            if (w_cnt_inc >= c_wg_min) begin
               w_fire     = 1'b1;
               w_ev       = c_ev_wg;
               w_cnt_clr  = 1'b1;
               w_state_nx = r_kd ? MARK : IDLE;
               w_ret_nx   = IDLE;
            end else if (r_kd) begin
               w_state_nx = MARK;
               w_ret_nx   = GAP;
               w_cnt_clr  = 1'b1;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_cnt_clr  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state <= IDLE;
         r_ret   <= IDLE;
         r_cnt   <= '0;
         r_ev    <= 4'b0000;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ret   <= w_ret_nx;
         if (w_cnt_clr || (r_state == IDLE)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
         r_valid <= w_fire;
         if (w_fire) begin
            r_ev <= w_ev;
         end
      end
   end

   assign Dot   = r_ev[3];
   assign Dash  = r_ev[2];
   assign Lg    = r_ev[1];
   assign Wg    = r_ev[0];
   assign Valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_morse_key_classifier                                                  |
// | Directed stimulus with an expected-event queue for morse_key_classifier. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_morse_key_classifier;

   localparam logic [3:0] c_dot  = 4'b1000;
   localparam logic [3:0] c_dash = 4'b0100;
   localparam logic [3:0] c_lg   = 4'b0010;
   localparam logic [3:0] c_wg   = 4'b0001;

   logic Clk = 1'b0;
   logic Clr, Key, Tick;
   logic Dot, Dash, Lg, Wg, Valid;

   int checks   = 0;
   int failures = 0;
   logic [3:0] sb[$];
   logic       r_prev_valid = 1'b0;

   morse_key_classifier dut (
      .Clk   (Clk),
      .Clr   (Clr),
      .Key   (Key),
      .Tick  (Tick),
      .Dot   (Dot),
      .Dash  (Dash),
      .Lg    (Lg),
      .Wg    (Wg),
      .Valid (Valid)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every Valid pops the next expected event; an empty queue means a spurious event
   always @(negedge Clk) begin
      if (Valid) begin
         chk("valid_one_cycle", {15'd0, r_prev_valid}, 16'd0);
         if (sb.size() == 0) begin
            chk("unexpected_event", {12'd0, Dot, Dash, Lg, Wg}, 16'd0);
         end else begin
            chk("event", {12'd0, Dot, Dash, Lg, Wg}, {12'd0, sb.pop_front()});
         end
      end
      r_prev_valid = Valid;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         Tick = 1'b1;
         cyc(1);
         Tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic press();
      Key = 1'b1;
      cyc(8);
   endtask

   task automatic release_key();
      Key = 1'b0;
      cyc(8);
   endtask

   task automatic letter_end();
      ticks(7);
      sb.push_back(c_lg);
      ticks(1);
      ticks(19);
      sb.push_back(c_wg);
      ticks(1);
   endtask

   initial begin
      Clr  = 1'b1;
      Key  = 1'b0;
      Tick = 1'b0;
      cyc(3);
      chk("reset_outputs", {11'd0, Dot, Dash, Lg, Wg, Valid}, 16'd0);
      Clr = 1'b0;
      cyc(2);

      // single dot, letter gap, word gap, then silence
      press();
      ticks(4);
      sb.push_back(c_dot);
      release_key();
      letter_end();
      cyc(2);
      chk("wg_held", {14'd0, Wg, Valid}, 16'b10);
      ticks(40);

      // "A": dot, 4-tick intra gap, dash
      press();
      ticks(4);
      sb.push_back(c_dot);
      release_key();
      ticks(4);
      press();
      ticks(12);
      sb.push_back(c_dash);
      release_key();
      letter_end();

      // raw glitch shorter than debounce window
      Key = 1'b1;
      cyc(2);
      Key = 1'b0;
      cyc(10);
      chk("glitch_kd", {15'd0, dut.r_kd}, 16'd0);

      // zero-tick debounced mark in SPACE is dropped and restarts the space count
      press();
      ticks(4);
      sb.push_back(c_dot);
      release_key();
      ticks(5);
      press();
      release_key();
      letter_end();

      // long hold saturates the counter
      press();
      ticks(300);
      chk("cnt_saturated", {8'd0, dut.r_cnt}, 16'd255);
      sb.push_back(c_dash);
      release_key();
      letter_end();

      // debounced press coinciding with the 8th space tick
      press();
      ticks(4);
      sb.push_back(c_dot);
      release_key();
      ticks(7);
      sb.push_back(c_lg);
      Key = 1'b1;
      cyc(6);
      Tick = 1'b1;
      cyc(1);
      Tick = 1'b0;
      cyc(1);
      ticks(4);
      sb.push_back(c_dot);
      release_key();
      letter_end();

      // clear in the middle of a mark
      press();
      ticks(6);
      Clr = 1'b1;
      #1;
      chk("clr_outputs", {11'd0, Dot, Dash, Lg, Wg, Valid}, 16'd0);
      chk("clr_state", {14'd0, dut.r_state}, 16'd0);
      cyc(2);
      Clr = 1'b0;
      cyc(2);
      release_key();
      ticks(30);
      chk("clr_no_event_state", {14'd0, dut.r_state}, 16'd0);

      cyc(4);
      chk("queue_drained", sb.size(), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
